pass_controller: RTL

Per-pass sequencer between the layer scheduler and the GLB/NoC datapath. Once the scheduler issues `pass_start`, it runs one processing pass through fixed phases: filter load, psum/bias preload, ifmap stream, array drain, psum write-back. It counts word transfers against per-pass word counts and exports phase and word index for GLB address generation. It also supplies the `pass_ready`/`pass_done` handshake that the scheduler consumes.

---
 rtl/pass_controller_if.sv | 31 +++
 rtl/pass_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pass_controller_if.sv
// Scheduler/datapath <-> pass_controller signal bundle.
// master = scheduler/GLB side, slave = pass_controller.
interface pass_controller_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 pass_start;
    logic                 pass_ready;
    logic                 pass_done;
    logic                 bias_sel;
    logic [CNT_WIDTH-1:0] filter_words;
    logic [CNT_WIDTH-1:0] psum_words;
    logic [CNT_WIDTH-1:0] ifmap_words;
    logic [2:0]           phase;
    logic                 xfer_en;
    logic                 xfer_fire;
    logic                 bias_load;
    logic [CNT_WIDTH-1:0] word_idx;
    logic                 array_busy;

    modport master (
        output pass_start, bias_sel, filter_words, psum_words, ifmap_words,
               xfer_fire, array_busy,
        input  pass_ready, pass_done, phase, xfer_en, bias_load, word_idx
    );

    modport slave (
        input  pass_start, bias_sel, filter_words, psum_words, ifmap_words,
               xfer_fire, array_busy,
        output pass_ready, pass_done, phase, xfer_en, bias_load, word_idx
    );
endinterface

// File: rtl/pass_controller.sv
// Per-pass sequencer: FILTER -> PSUM_IN -> IFMAP -> DRAIN -> PSUM_OUT -> DONE.
// Empty transfer phases are skipped in the same transition that would enter
// them. All outputs come straight from registered state/counter.
// CNT_WIDTH must match the width the connected interface was built with.
module pass_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,   // asynchronous, active low
    pass_controller_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILTER   = 3'd1,
        S_PSUM_IN  = 3'd2,
        S_IFMAP    = 3'd3,
        S_DRAIN    = 3'd4,
        S_PSUM_OUT = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] widx_q, widx_d;
    logic [CNT_WIDTH-1:0] fw_q, fw_d;
    logic [CNT_WIDTH-1:0] pw_q, pw_d;
    logic [CNT_WIDTH-1:0] iw_q, iw_d;
    logic                 bias_q, bias_d;

    logic                 xfer_phase;
    logic [CNT_WIDTH-1:0] cur_cnt;
    logic                 last_word;

    // First non-empty phase strictly after `from`. DRAIN is never skipped;
    // PSUM_IN/PSUM_OUT share the psum count.
    function automatic state_e next_phase(input state_e from,
                                          input logic [CNT_WIDTH-1:0] fw,
                                          input logic [CNT_WIDTH-1:0] pw,
                                          input logic [CNT_WIDTH-1:0] iw);
        state_e nxt;
        nxt = S_IDLE;
        case (from)
            S_IDLE: begin
                if (fw != '0)      nxt = S_FILTER;
                else if (pw != '0) nxt = S_PSUM_IN;
                else if (iw != '0) nxt = S_IFMAP;
                else               nxt = S_DRAIN;
            end
            S_FILTER: begin
                if (pw != '0)      nxt = S_PSUM_IN;
                else if (iw != '0) nxt = S_IFMAP;
                else               nxt = S_DRAIN;
            end
            S_PSUM_IN:  nxt = (iw != '0) ? S_IFMAP : S_DRAIN;
            S_IFMAP:    nxt = S_DRAIN;
            S_DRAIN:    nxt = (pw != '0) ? S_PSUM_OUT : S_DONE;
            S_PSUM_OUT: nxt = S_DONE;
            default:    nxt = S_IDLE;
        endcase
        return nxt;
    endfunction

    // Word count governing the current transfer phase.
    always_comb begin
        cur_cnt    = '0;
        xfer_phase = 1'b0;
        case (state_q)
            S_FILTER:   begin cur_cnt = fw_q; xfer_phase = 1'b1; end
            S_PSUM_IN:  begin cur_cnt = pw_q; xfer_phase = 1'b1; end
            S_IFMAP:    begin cur_cnt = iw_q; xfer_phase = 1'b1; end
            S_PSUM_OUT: begin cur_cnt = pw_q; xfer_phase = 1'b1; end
            default:    begin cur_cnt = '0;   xfer_phase = 1'b0; end
        endcase
    end

    // A phase is only entered with a non-zero count, so cur_cnt-1 never wraps.
    assign last_word = xfer_phase && bus.xfer_fire && (widx_q == cur_cnt - ONE);

    // Next-state, word counter and capture logic.
    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        fw_d    = fw_q;
        pw_d    = pw_q;
        iw_d    = iw_q;
        bias_d  = bias_q;
        case (state_q)
            S_IDLE: begin
                if (bus.pass_start) begin
                    fw_d    = bus.filter_words;
                    pw_d    = bus.psum_words;
                    iw_d    = bus.ifmap_words;
                    bias_d  = bus.bias_sel;
                    widx_d  = '0;
                    state_d = next_phase(S_IDLE, bus.filter_words,
                                         bus.psum_words, bus.ifmap_words);
                end
            end
            S_FILTER, S_PSUM_IN, S_IFMAP, S_PSUM_OUT: begin
                if (last_word) begin
                    widx_d  = '0;
                    state_d = next_phase(state_q, fw_q, pw_q, iw_q);
                end else if (bus.xfer_fire) begin
                    widx_d  = widx_q + ONE;
                end
            end
            S_DRAIN: begin
                if (!bus.array_busy)
                    state_d = next_phase(S_DRAIN, fw_q, pw_q, iw_q);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and pass-context registers; reset aborts any pass in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            widx_q  <= '0;
            fw_q    <= '0;
            pw_q    <= '0;
            iw_q    <= '0;
            bias_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            fw_q    <= fw_d;
            pw_q    <= pw_d;
            iw_q    <= iw_d;
            bias_q  <= bias_d;
        end
    end

    assign bus.pass_ready = (state_q == S_IDLE);
    assign bus.pass_done  = (state_q == S_DONE);
    assign bus.phase      = state_q;
    assign bus.xfer_en    = xfer_phase;
    assign bus.bias_load  = (state_q == S_PSUM_IN) && bias_q;
    assign bus.word_idx   = widx_q;   // cleared on every phase exit

endmodule
